// File: rtl/bythoven_pkg.sv
// Shared opcodes, instruction field positions, FSM states and the note length helper
// for the note scheduler and its beat divider.
package bythoven_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_DIV    = 3'd3,
      ST_ISSUE  = 3'd4,
      ST_PLAY   = 3'd5
   } state_t;

   localparam logic       OP_NOTE  = 1'b1;
   localparam logic [3:0] OP_END   = 4'h0;
   localparam logic [3:0] OP_BPM   = 4'h1;

   localparam int NOTE_BIT = 15;
   localparam int OP_MSB   = 15;
   localparam int OP_LSB   = 12;
   localparam int LEN_MSB  = 11;
   localparam int LEN_LSB  = 8;
   localparam int BPM_MSB  = 11;
   localparam int BPM_LSB  = 0;

   // A quarter beat times (length code + 1); 30 x 5 bits cannot overflow 36 bits.
   function automatic logic [35:0] note_length(input logic [31:0] beat, input logic [3:0] len);
      logic [35:0] w_quarter;
      logic [35:0] w_mult;
      w_quarter = {6'd0, beat[31:2]};
      w_mult    = {31'd0, ({1'b0, len} + 5'd1)};
      return w_quarter * w_mult;
   endfunction

endpackage

// File: rtl/note_scheduler_beat_divider.sv
// Restoring 32-by-12-bit unsigned divider: one quotient bit per cycle, 32 cycles,
// then a one-cycle o_done pulse with the quotient held on o_quotient.
module beat_divider
   import bythoven_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [31:0] i_dividend,
   input  logic [11:0] i_divisor,
   output logic [31:0] o_quotient,
   output logic        o_done
);

   logic [31:0] r_quo;
   logic [11:0] r_rem;
   logic [11:0] r_div;
   logic [5:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic [11:0] w_low;
   logic        w_fits;

   // A set remainder MSB means the shifted value exceeds any 12-bit divisor; the
   // 12-bit wrap of w_low - r_div still yields the true remainder in that case.
   assign w_low  = {r_rem[10:0], r_quo[31]};
   assign w_fits = r_rem[11] | (w_low >= r_div);

   // Shift/subtract iteration and completion pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_quo  <= 32'd0;
         r_rem  <= 12'd0;
         r_div  <= 12'd0;
         r_cnt  <= 6'd0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start && !r_busy) begin
            r_quo  <= i_dividend;
            r_rem  <= 12'd0;
            r_div  <= i_divisor;
            r_cnt  <= 6'd32;
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_quo <= {r_quo[30:0], w_fits};
            r_rem <= w_fits ? (w_low - r_div) : w_low;
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_busy <= 1'b1;
            end
         end else begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_quotient = r_quo;
   assign o_done     = r_done;

endmodule

// File: rtl/note_scheduler.sv
// Instruction-driven note sequencer: fetches 16-bit words from SRAM, handles tempo
// and end instructions, and hands notes to a tone generator with a timed gate.
module note_scheduler
   import bythoven_pkg::*;
#(
   parameter int CLK_HZ      = 50000000,
   parameter int DEFAULT_BPM = 96,
   parameter int SRAM_WAIT   = 3,
   parameter int GAP_CYCLES  = 500000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   output logic [17:0] SRAM_A,
   input  logic [15:0] SRAM_D,
   output logic        note_valid,
   input  logic        note_ready,
   output logic [15:0] note_ins,
   output logic        note_gate,
   output logic        busy,
   output logic        done
);

   localparam logic [63:0] DIVIDEND_W   = 64'(CLK_HZ) * 64'd60;
   localparam logic [31:0] DIVIDEND     = DIVIDEND_W[31:0];
   localparam logic [31:0] BEAT_DEFAULT = 32'(DIVIDEND_W / 64'(DEFAULT_BPM));
   localparam logic [7:0]  WAIT_LAST    = 8'((SRAM_WAIT < 1) ? 0 : SRAM_WAIT - 1);
   localparam logic [35:0] GAP36        = 36'(GAP_CYCLES);

   state_t      r_state;
   logic [17:0] r_pc;
   logic [17:0] r_sram_a;
   logic [7:0]  r_wait;
   logic [15:0] r_ins;
   logic [15:0] r_note_ins;
   logic [11:0] r_bpm;
   logic [31:0] r_beat;
   logic [35:0] r_note_cycles;
   logic [35:0] r_remaining;
   logic        r_note_valid;
   logic        r_note_gate;
   logic        r_busy;
   logic        r_done;
   logic        r_div_start;
   logic [17:0] w_pc_next;
   logic [31:0] w_quotient;
   logic        w_div_done;

   assign w_pc_next = r_pc + 18'd1;

   beat_divider u_div (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_start    (r_div_start),
      .i_dividend (DIVIDEND),
      .i_divisor  (r_bpm),
      .o_quotient (w_quotient),
      .o_done     (w_div_done)
   );

   // Sequencer FSM; SRAM_A always tracks the pc it is loaded with on entry to FETCH.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state       <= ST_IDLE;
         r_pc          <= 18'd0;
         r_sram_a      <= 18'd0;
         r_wait        <= 8'd0;
         r_ins         <= 16'd0;
         r_note_ins    <= 16'd0;
         r_bpm         <= 12'(DEFAULT_BPM);
         r_beat        <= BEAT_DEFAULT;
         r_note_cycles <= 36'd0;
         r_remaining   <= 36'd0;
         r_note_valid  <= 1'b0;
         r_note_gate   <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_div_start   <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_div_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_pc     <= 18'd0;
                  r_sram_a <= 18'd0;
                  r_wait   <= 8'd0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_FETCH;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (r_wait == WAIT_LAST) begin
                  r_ins   <= SRAM_D;
                  r_wait  <= 8'd0;
                  r_state <= ST_DECODE;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            ST_DECODE: begin
               if (r_ins[NOTE_BIT] == OP_NOTE) begin
                  r_note_ins    <= r_ins;
                  r_note_cycles <= note_length(r_beat, r_ins[LEN_MSB:LEN_LSB]);
                  r_note_valid  <= 1'b1;
                  r_state       <= ST_ISSUE;
               end else if (r_ins[OP_MSB:OP_LSB] == OP_END) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if ((r_ins[OP_MSB:OP_LSB] == OP_BPM) && (r_ins[BPM_MSB:BPM_LSB] != 12'd0)) begin
                  r_bpm       <= r_ins[BPM_MSB:BPM_LSB];
                  r_div_start <= 1'b1;
                  r_state     <= ST_DIV;
               end else begin
                  r_pc     <= w_pc_next;
                  r_sram_a <= w_pc_next;
                  r_state  <= ST_FETCH;
               end
            end
            ST_DIV: begin
               if (w_div_done) begin
                  r_beat   <= w_quotient;
                  r_pc     <= w_pc_next;
                  r_sram_a <= w_pc_next;
                  r_state  <= ST_FETCH;
               end else begin
                  r_state <= ST_DIV;
               end
            end
            ST_ISSUE: begin
               if (note_ready) begin
                  r_note_valid <= 1'b0;
                  r_remaining  <= r_note_cycles;
                  r_note_gate  <= (r_note_cycles > GAP36);
                  r_state      <= ST_PLAY;
               end else begin
                  r_note_valid <= 1'b1;
               end
            end
            ST_PLAY: begin
               // remaining counts N..1, so the gate is high for exactly N - GAP cycles
               if (r_remaining <= 36'd1) begin
                  r_note_gate <= 1'b0;
                  r_pc        <= w_pc_next;
                  r_sram_a    <= w_pc_next;
                  r_state     <= ST_FETCH;
               end else begin
                  r_remaining <= r_remaining - 36'd1;
                  r_note_gate <= ((r_remaining - 36'd1) > GAP36);
               end
            end
            default: begin
               r_note_valid <= 1'b0;
               r_note_gate  <= 1'b0;
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   assign SRAM_A     = r_sram_a;
   assign note_valid = r_note_valid;
   assign note_ins   = r_note_ins;
   assign note_gate  = r_note_gate;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboard bench for note_scheduler: stimulus queues expected note events, a
// negedge monitor measures what the DUT presents and compares against the queue.
module tb_note_scheduler;

   localparam int EV_LEAD   = 0;
   localparam int EV_NOTE   = 1;
   localparam int EV_VWAIT  = 2;
   localparam int EV_PLAY   = 3;
   localparam int EV_GATE   = 4;
   localparam int EV_STABLE = 5;
   localparam int EV_DONE   = 6;

   typedef struct {
      int     kind;
      longint val;
   } ev_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic        note_ready = 1'b0;
   logic [17:0] SRAM_A;
   logic [15:0] SRAM_D;
   logic        note_valid;
   logic [15:0] note_ins;
   logic        note_gate;
   logic        busy;
   logic        done;
   logic [15:0] mem [0:15];

   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail = 0;
   int  ready_hold = 0;
   int  vcnt = 0;
   bit  chk_lead = 1'b0;

   int          m_lead = 0;
   int          m_vwait = 0;
   int          m_cnt = 0;
   int          m_gate = 0;
   bit          m_first = 1'b1;
   bit          m_in_play = 1'b0;
   bit          m_stable = 1'b1;
   logic [17:0] m_addr = 18'd0;
   logic [15:0] m_ins = 16'd0;

   note_scheduler #(
      .CLK_HZ      (960),
      .DEFAULT_BPM (96),
      .SRAM_WAIT   (3),
      .GAP_CYCLES  (200)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start),
      .SRAM_A     (SRAM_A),
      .SRAM_D     (SRAM_D),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .note_ins   (note_ins),
      .note_gate  (note_gate),
      .busy       (busy),
      .done       (done)
   );

   always #5 CLK = ~CLK;

   assign SRAM_D = (SRAM_A < 18'd16) ? mem[SRAM_A[3:0]] : 16'h0000;

   function automatic string kname(input int k);
      case (k)
         EV_LEAD:   return "lead_cycles";
         EV_NOTE:   return "note_ins";
         EV_VWAIT:  return "valid_wait";
         EV_PLAY:   return "play_len";
         EV_GATE:   return "gate_high";
         EV_STABLE: return "ins_stable";
         EV_DONE:   return "done";
         default:   return "unknown";
      endcase
   endfunction

   task automatic expect_ev(input int k, input longint v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic check_ev(input int k, input longint v);
      ev_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_%s: actual %0d, required no event", kname(k), v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.val != v) begin
            n_fail++;
            $display("FAIL %s: actual %s=%0d, required %s=%0d",
                     kname(e.kind), kname(k), v, kname(e.kind), e.val);
         end
      end
   endtask

   task automatic check(input string name, input longint act, input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d", name, act, req);
      end
   endtask

   task automatic load_prog(input logic [15:0] p0, input logic [15:0] p1,
                            input logic [15:0] p2, input logic [15:0] p3);
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      mem[0] = p0;
      mem[1] = p1;
      mem[2] = p2;
      mem[3] = p3;
   endtask

   task automatic pulse_start();
      @(posedge CLK); #2 start = 1'b1;
      @(posedge CLK); #2 start = 1'b0;
   endtask

   task automatic run_prog(input string name, input bit stray);
      bit finished;
      pulse_start();
      if (stray) begin
         repeat (100) @(posedge CLK);
         #2 start = 1'b1;
         @(posedge CLK); #2 start = 1'b0;
      end
      finished = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge CLK);
         if (!busy) begin
            finished = 1'b1;
            break;
         end
      end
      if (!finished) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout_%s: actual busy=1, required busy=0 within 20000 cycles", name);
      end
   endtask

   // Tone-generator model: withhold ready for ready_hold cycles of note_valid.
   initial begin
      forever begin
         @(posedge CLK); #2;
         if (note_valid) begin
            note_ready = (vcnt >= ready_hold);
            vcnt++;
         end else begin
            vcnt = 0;
            note_ready = 1'b0;
         end
      end
   end

   // Monitor: measures handshakes, play length, gate time and done pulses.
   always @(negedge CLK) begin
      if (RST) begin
         m_lead = 0; m_vwait = 0; m_first = 1'b1; m_in_play = 1'b0;
      end else begin
         if (!busy) begin
            m_lead = 0;
            m_first = 1'b1;
         end
         if (m_in_play) begin
            if (!busy) begin
               m_in_play = 1'b0;
            end else if (SRAM_A != m_addr) begin
               check_ev(EV_PLAY, longint'(m_cnt));
               check_ev(EV_GATE, longint'(m_gate));
               check_ev(EV_STABLE, longint'(m_stable));
               m_in_play = 1'b0;
            end else begin
               m_cnt++;
               if (note_gate) m_gate++;
               if (note_ins != m_ins) m_stable = 1'b0;
            end
         end
         if (busy && m_first) m_lead++;
         if (note_valid && !note_ready) m_vwait++;
         if (note_valid && note_ready) begin
            if (m_first && chk_lead) check_ev(EV_LEAD, longint'(m_lead));
            m_first = 1'b0;
            check_ev(EV_NOTE, longint'(note_ins));
            check_ev(EV_VWAIT, longint'(m_vwait));
            m_vwait = 0;
            m_in_play = 1'b1;
            m_cnt = 0;
            m_gate = 0;
            m_stable = 1'b1;
            m_addr = SRAM_A;
            m_ins = note_ins;
         end
         if (done) check_ev(EV_DONE, 64'd1);
      end
   end

   initial begin
      bit gate_seen;
      load_prog(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      #3;
      check("rst_sram_a", longint'(SRAM_A), 0);
      check("rst_note_ins", longint'(note_ins), 0);
      check("rst_note_valid", longint'(note_valid), 0);
      check("rst_note_gate", longint'(note_gate), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;

      // bpm=0 keeps default 600-cycle beat, no DIV: lead = 3+1+3+1+1
      load_prog(16'h1000, 16'h8305, 16'h0000, 16'h0000);
      chk_lead = 1'b1; ready_hold = 0;
      expect_ev(EV_LEAD, 9);
      expect_ev(EV_NOTE, 16'h8305); expect_ev(EV_VWAIT, 0);
      expect_ev(EV_PLAY, 600); expect_ev(EV_GATE, 400); expect_ev(EV_STABLE, 1);
      expect_ev(EV_DONE, 1);
      run_prog("bpm0", 1'b0);

      // bpm 96 -> 600; len 3 -> 600 cycles; len 0 -> 150 cycles, gate never high
      chk_lead = 1'b0;
      load_prog(16'h1060, 16'h8305, 16'h8005, 16'h0000);
      expect_ev(EV_NOTE, 16'h8305); expect_ev(EV_VWAIT, 0);
      expect_ev(EV_PLAY, 600); expect_ev(EV_GATE, 400); expect_ev(EV_STABLE, 1);
      expect_ev(EV_NOTE, 16'h8005); expect_ev(EV_VWAIT, 0);
      expect_ev(EV_PLAY, 150); expect_ev(EV_GATE, 0); expect_ev(EV_STABLE, 1);
      expect_ev(EV_DONE, 1);
      run_prog("bpm96", 1'b0);

      // bpm 192 -> beat 300, NOP skipped, ready held off 10 cycles, stray start ignored
      load_prog(16'h10C0, 16'h2000, 16'h8305, 16'h0000);
      ready_hold = 10;
      expect_ev(EV_NOTE, 16'h8305); expect_ev(EV_VWAIT, 10);
      expect_ev(EV_PLAY, 300); expect_ev(EV_GATE, 100); expect_ev(EV_STABLE, 1);
      expect_ev(EV_DONE, 1);
      run_prog("bpm192_hold", 1'b1);

      // tempo persists across runs: 75 * 11 = 825 cycles
      load_prog(16'h8A42, 16'h0000, 16'h0000, 16'h0000);
      ready_hold = 0;
      expect_ev(EV_NOTE, 16'h8A42); expect_ev(EV_VWAIT, 0);
      expect_ev(EV_PLAY, 825); expect_ev(EV_GATE, 625); expect_ev(EV_STABLE, 1);
      expect_ev(EV_DONE, 1);
      run_prog("len10", 1'b0);

      // reset in the middle of a 1200-cycle note at address 1
      load_prog(16'h2000, 16'h8F05, 16'h0000, 16'h0000);
      expect_ev(EV_NOTE, 16'h8F05); expect_ev(EV_VWAIT, 0);
      pulse_start();
      gate_seen = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge CLK);
         if (note_gate) begin
            gate_seen = 1'b1;
            break;
         end
      end
      check("gate_before_reset", longint'(gate_seen), 1);
      repeat (20) @(posedge CLK);
      #3 RST = 1'b1;
      #1;
      check("async_rst_gate", longint'(note_gate), 0);
      check("async_rst_busy", longint'(busy), 0);
      check("async_rst_valid", longint'(note_valid), 0);
      check("async_rst_sram_a", longint'(SRAM_A), 0);
      @(posedge CLK); #2 RST = 1'b0;

      // after reset: fetch from 0 with default beat 600 restored
      load_prog(16'h8005, 16'h0000, 16'h0000, 16'h0000);
      chk_lead = 1'b1;
      expect_ev(EV_LEAD, 5);
      expect_ev(EV_NOTE, 16'h8005); expect_ev(EV_VWAIT, 0);
      expect_ev(EV_PLAY, 150); expect_ev(EV_GATE, 0); expect_ev(EV_STABLE, 1);
      expect_ev(EV_DONE, 1);
      run_prog("after_reset", 1'b0);

      repeat (5) @(posedge CLK);
      check("events_left", longint'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
